// File: rtl/calc_operand_sequencer.sv
// Operand/control sequencer for the calculator ALU path: captures two switch operands,
// starts the ALU, waits with a timeout and holds the result. Define CALC_CHAIN_EN for result chaining.
module calc_operand_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  sw_in,
    input  logic [1:0]  op_sel,
    input  logic        load_btn,
    input  logic        clear,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic [15:0] opa,
    output logic [15:0] opb,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    output logic        busy,
    output logic [15:0] result_out,
    output logic        result_valid,
    output logic        error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HAVE_A = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_SHOW   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           fsm_state;
    state_t           fsm_next;
    logic             load_q;
    logic             ld;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic [15:0]      sw_ext;

    logic             load_a;
    logic             load_b;
    logic             chain;
    logic             take_done;
    logic             take_timeout;
    logic             show_exit;
    logic             cnt_clr;
    logic             cnt_inc;

    assign ld          = load_btn & ~load_q;
    assign timeout_hit = (cnt == TIMEOUT_LAST);
    assign sw_ext      = {6'b000000, sw_in};

    assign state     = fsm_state;
    assign alu_start = (fsm_state == S_START);
    assign busy      = (fsm_state == S_START) || (fsm_state == S_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state <= S_IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    // clear overrides every event, so no strobe fires while it is asserted
    always_comb begin
        fsm_next     = fsm_state;
        load_a       = 1'b0;
        load_b       = 1'b0;
        chain        = 1'b0;
        take_done    = 1'b0;
        take_timeout = 1'b0;
        show_exit    = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        if (clear) begin
            fsm_next = S_IDLE;
        end else begin
            case (fsm_state)
                S_IDLE: begin
                    if (ld) begin
                        load_a   = 1'b1;
                        fsm_next = S_HAVE_A;
                    end
                end
                S_HAVE_A: begin
                    if (ld) begin
                        load_b   = 1'b1;
                        fsm_next = S_START;
                    end
                end
                S_START: begin
                    cnt_clr  = 1'b1;
                    fsm_next = S_WAIT;
                end
                S_WAIT: begin
                    cnt_inc = 1'b1;
                    if (alu_done) begin
                        take_done = 1'b1;
                        fsm_next  = S_SHOW;
                    end else if (timeout_hit) begin
                        take_timeout = 1'b1;
                        fsm_next     = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (ld) begin
`ifdef CALC_CHAIN_EN
                        if (!error) begin
                            chain    = 1'b1;
                            fsm_next = S_START;
                        end else begin
                            load_a    = 1'b1;
                            show_exit = 1'b1;
                            fsm_next  = S_HAVE_A;
                        end
`else
                        load_a    = 1'b1;
                        show_exit = 1'b1;
                        fsm_next  = S_HAVE_A;
`endif
                    end
                end
                default: fsm_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q       <= 1'b0;
            cnt          <= '0;
            opa          <= '0;
            opb          <= '0;
            alu_op       <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            load_q <= load_btn;
            if (clear) begin
                cnt          <= '0;
                result_valid <= 1'b0;
                error        <= 1'b0;
            end else begin
                if (cnt_clr) begin
                    cnt <= '0;
                end else if (cnt_inc && (cnt != '1)) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (load_a) begin
                    opa <= sw_ext;
                end
                if (load_b) begin
                    opb    <= sw_ext;
                    alu_op <= op_sel;
                end
                if (chain) begin
                    opa          <= result_out;
                    opb          <= sw_ext;
                    alu_op       <= op_sel;
                    result_valid <= 1'b0;
                end
                if (take_done) begin
                    result_out   <= alu_result;
                    result_valid <= 1'b1;
                    error        <= 1'b0;
                end
                if (take_timeout) begin
                    result_out   <= 16'hFFFF;
                    result_valid <= 1'b0;
                    error        <= 1'b1;
                end
                if (show_exit) begin
                    result_valid <= 1'b0;
                    error        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with TIMEOUT_CYCLES=8; honours CALC_CHAIN_EN.
module tb_calc_operand_sequencer;

    logic        clk;
    logic        reset;
    logic [9:0]  sw_in;
    logic [1:0]  op_sel;
    logic        load_btn;
    logic        clear;
    logic [15:0] alu_result;
    logic        alu_done;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        busy;
    logic [15:0] result_out;
    logic        result_valid;
    logic        error;
    logic [2:0]  state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    calc_operand_sequencer #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_in(sw_in),
        .op_sel(op_sel),
        .load_btn(load_btn),
        .clear(clear),
        .alu_result(alu_result),
        .alu_done(alu_done),
        .opa(opa),
        .opb(opb),
        .alu_op(alu_op),
        .alu_start(alu_start),
        .busy(busy),
        .result_out(result_out),
        .result_valid(result_valid),
        .error(error),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        sw_in      = '0;
        op_sel     = '0;
        load_btn   = 1'b0;
        clear      = 1'b0;
        alu_result = '0;
        alu_done   = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_opa", opa, 0);
        check("rst_opb", opb, 0);
        check("rst_result", result_out, 0);
        check("rst_valid", result_valid, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_start", alu_start, 0);
        reset = 1'b0;
        tick();

        // basic operation
        sw_in = 10'b1101100110; load_btn = 1'b1; tick();
        check("a_opa", opa, 16'h0366);
        check("a_state", state, 1);
        load_btn = 1'b0; tick();
        sw_in = 10'b1010101010; op_sel = 2'd2; load_btn = 1'b1; tick();
        check("b_opb", opb, 16'h02AA);
        check("b_aluop", alu_op, 2);
        check("b_start", alu_start, 1);
        check("b_state", state, 2);
        check("b_busy", busy, 1);
        load_btn = 1'b0; tick();
        check("wait_start_low", alu_start, 0);
        check("wait_state", state, 3);
        check("wait_busy", busy, 1);
        sw_in = 10'h155; load_btn = 1'b1; tick();
        load_btn = 1'b0;
        check("wait_ld_opb", opb, 16'h02AA);
        check("wait_ld_state", state, 3);
        alu_result = 16'h0610; alu_done = 1'b1; tick();
        alu_done = 1'b0;
        check("done_result", result_out, 16'h0610);
        check("done_valid", result_valid, 1);
        check("done_state", state, 4);
        check("done_busy", busy, 0);
        check("done_error", error, 0);
        tick();
        check("show_hold", result_out, 16'h0610);
        check("show_state", state, 4);

        // ld in SHOW: chaining or restart
        sw_in = 10'h001; op_sel = 2'd1; load_btn = 1'b1; tick();
`ifdef CALC_CHAIN_EN
        check("chain_opa", opa, 16'h0610);
        check("chain_opb", opb, 16'h0001);
        check("chain_state", state, 2);
        check("chain_start", alu_start, 1);
`else
        check("show_ld_opa", opa, 16'h0001);
        check("show_ld_state", state, 1);
`endif
        check("show_ld_valid", result_valid, 0);
        load_btn = 1'b0; tick();
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clr_state", state, 0);

        // held button: single capture, zero-extension of all-ones switches
        sw_in = 10'h3FF; load_btn = 1'b1;
        repeat (10) tick();
        check("hold_opa", opa, 16'h03FF);
        check("hold_state", state, 1);
        load_btn = 1'b0; tick();

        // alu_done outside WAIT is ignored
        alu_result = 16'h1234; alu_done = 1'b1; tick();
        alu_done = 1'b0;
        check("stray_done_valid", result_valid, 0);
        check("stray_done_result", result_out, 16'h0610);
        check("stray_done_state", state, 1);

        // timeout: WAIT lasts exactly 8 cycles
        sw_in = 10'h005; op_sel = 2'd3; load_btn = 1'b1; tick();
        check("to_start", state, 2);
        load_btn = 1'b0; tick();
        repeat (7) tick();
        check("to_still_wait", state, 3);
        tick();
        check("to_state", state, 4);
        check("to_error", error, 1);
        check("to_result", result_out, 16'hFFFF);
        check("to_valid", result_valid, 0);

        // after an error, ld in SHOW restarts even with chaining
        sw_in = 10'h00A; load_btn = 1'b1; tick();
        check("err_ld_state", state, 1);
        check("err_ld_opa", opa, 16'h000A);
        check("err_ld_error", error, 0);
        load_btn = 1'b0; tick();
        sw_in = 10'h014; op_sel = 2'd0; load_btn = 1'b1; tick();
        load_btn = 1'b0; tick();
        repeat (7) tick();
        check("tie_wait", state, 3);
        alu_result = 16'h001E; alu_done = 1'b1; tick();
        alu_done = 1'b0;
        check("tie_valid", result_valid, 1);
        check("tie_error", error, 0);
        check("tie_result", result_out, 16'h001E);

        // clear retains operands and result
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clr2_state", state, 0);
        check("clr2_valid", result_valid, 0);
        check("clr2_result", result_out, 16'h001E);
        sw_in = 10'h0C3; load_btn = 1'b1; tick();
        load_btn = 1'b0; tick();
        sw_in = 10'h011; op_sel = 2'd1; load_btn = 1'b1; tick();
        load_btn = 1'b0; tick();
        tick();
        check("pre_clr_state", state, 3);
        clear = 1'b1; tick();
        clear = 1'b0;
        check("clr_wait_state", state, 0);
        check("clr_wait_busy", busy, 0);
        check("clr_wait_opa", opa, 16'h00C3);
        check("clr_wait_opb", opb, 16'h0011);

        // asynchronous reset mid-WAIT
        load_btn = 1'b1; tick();
        load_btn = 1'b0; tick();
        load_btn = 1'b1; tick();
        load_btn = 1'b0; tick();
        tick();
        check("pre_rst_state", state, 3);
        check("pre_rst_aluop", alu_op, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_opa", opa, 0);
        check("arst_opb", opb, 0);
        check("arst_aluop", alu_op, 0);
        check("arst_result", result_out, 0);
        check("arst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
Control FSM for the pocket-calculator operand path. It captures two 10-bit switch operands on successive load presses and zero-extends each to 16 bits. It then issues one start pulse plus opcode to the ALU, waits for completion with a timeout, and holds the 16-bit result for the display. It sits between the switch/button inputs and the ALU and display blocks.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before the error path is taken (1..65535)
CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
sw_in  input  10  operand switches
op_sel  input  2  ALU opcode switches
load_btn  input  1  load button level (already synchronised upstream)
clear  input  1  synchronous clear to IDLE
alu_result  input  16  ALU result
alu_done  input  1  ALU completion pulse
opa  output  16  operand A, zero-extended
opb  output  16  operand B, zero-extended
alu_op  output  2  latched opcode
alu_start  output  1  one-cycle start pulse
busy  output  1  high in START and WAIT
result_out  output  16  latched result
result_valid  output  1  result_out is valid
error  output  1  ALU timeout occurred
state  output  3  FSM state: IDLE=0, HAVE_A=1, START=2, WAIT=3, SHOW=4

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0, state is IDLE, timeout counter is 0, internal load_q is 0.
- Load edge detection:
  - load_q <= load_btn every cycle.
  - ld = load_btn & ~load_q. A held button gives exactly one ld.
- Zero-extension:
  - An operand is captured as {6'b0, sw_in}. Bits 15:10 are never non-zero.
- Priority in every state: reset > clear > ld/alu_done/timeout.
  - clear gives state IDLE and zeroes result_valid, error, alu_start and the counter.
  - clear keeps opa, opb and result_out unchanged.
- IDLE:
  - On ld: opa <= ext(sw_in), go to HAVE_A.
- HAVE_A:
  - On ld: opb <= ext(sw_in), alu_op <= op_sel, go to START.
- START:
  - alu_start = 1 for exactly this cycle. Clear the counter, go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If alu_done: result_out <= alu_result, result_valid <= 1, error <= 0, go to SHOW.
  - Else if counter == TIMEOUT_CYCLES-1: result_out <= 16'hFFFF, error <= 1, result_valid <= 0, go to SHOW.
  - If alu_done and the timeout expire in the same cycle, alu_done wins.
- SHOW:
  - Outputs are held.
  - On ld (chaining disabled): result_valid <= 0, error <= 0, opa <= ext(sw_in), go to HAVE_A.
- Ignored events:
  - ld in START or WAIT is ignored; it is not queued.
  - alu_done outside WAIT is ignored.
- Latency:
  - ld sampled at edge n updates opa/opb at edge n.
  - alu_start is high in the cycle after the second ld edge.
  - result_valid rises on the edge that samples alu_done.
- Counter saturates; it never wraps within WAIT.

Optional Feature:
Macro CALC_CHAIN_EN.
- Defined: ld in SHOW with error==0 does the following, then goes directly to START:
  - opa <= result_out (full 16 bits, no truncation)
  - opb <= ext(sw_in)
  - alu_op <= op_sel
  - result_valid <= 0
  - If error==1, SHOW behaves as when the macro is undefined.
- Undefined: SHOW behaviour exactly as in Behaviour. No chaining logic is synthesised.

Test Plan:
- Basic operation:
  - Reset, then ld with sw_in=10'b1101100110, then ld with sw_in=10'b1010101010, op_sel=2.
  - Required: opa=16'h0366, opb=16'h02AA, alu_op=2, alu_start high exactly 1 cycle.
  - Then alu_done with alu_result=16'h0610: result_out=16'h0610, result_valid=1, state=4.
- Held button and extension:
  - Hold load_btn 10 cycles with sw_in=10'h3FF. Required: one capture only, opa=16'h03FF, state=1.
- Timeout:
  - TIMEOUT_CYCLES=8, no alu_done. Required: 8 cycles after START, error=1, result_out=16'hFFFF, result_valid=0, state=4.
  - Also: alu_done arriving in the same cycle as the timeout gives a valid result and error=0.
- Ignored and clear events:
  - ld and alu_done pulsed during WAIT before the real done: the ld is ignored and opb is unchanged.
  - clear asserted in WAIT: state=0, busy=0, opa is retained.
- Reset mid-operation:
  - Assert reset asynchronously mid-WAIT, between clock edges. Required: all outputs 0 immediately, without waiting for a clock edge.
- Chaining (with CALC_CHAIN_EN):
  - Result 16'h0610 is shown, then ld with sw_in=10'h001.
  - Required: opa=16'h0610, opb=16'h0001, START next cycle.
  - Without the macro: opa=16'h0001, state=1.
